// File: rtl/spi_pkg.sv
// Shared definitions for the SPI capture controller: FSM encoding and SPI mode.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DUMP    = 2'd3
  } state_t;

  localparam int SPI_MODE = 0;

  // CPOL sets the idle sclk level; modes 0 and 3 sample on the rising edge.
  localparam logic SCLK_IDLE   = (SPI_MODE >= 2) ? 1'b1 : 1'b0;
  localparam logic SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);

endpackage

// File: rtl/spi_capture_ctrl_if.sv
// Readout stream from the capture controller to its downstream consumer.
interface spi_capture_ctrl_if #(
    parameter int W = 8
) ();

    // A word transfers on every rising clock edge where tx_valid and tx_ready are both
    // high; once raised, tx_valid and tx_data hold steady until that transfer happens.
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for one asynchronous bus line with rise/fall detection.
module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q <= {3{IDLE_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    // The second flop is the synchronized level; the third only serves edge detection.
    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_capture_ctrl.sv
// Captures MOSI/MISO frame pairs from a sniffed SPI bus into a RAM, then streams them out.
module spi_capture_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int DEPTH     = 16
) (
    input  logic                     clk_12,
    input  logic                     rstn,
    input  logic                     sclk,
    input  logic                     MOSI,
    input  logic                     MISO,
    input  logic                     SS,
    input  logic                     arm,
    spi_capture_ctrl_if.master       tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   frame_count,
    output logic                     done,
    output state_t                   dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FRAME_LEN + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic miso_s, miso_rise, miso_fall;

    spi_sync_edge #(.IDLE_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk_i(clk_12), .rstn_i(rstn), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_12), .rstn_i(rstn), .d_i(SS),
        .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_12), .rstn_i(rstn), .d_i(MOSI),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_miso (
        .clk_i(clk_12), .rstn_i(rstn), .d_i(MISO),
        .q_o(miso_s), .rise_o(miso_rise), .fall_o(miso_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, ss_s, mosi_rise, mosi_fall, miso_rise, miso_fall};

    state_t                   state_q;
    logic                     arm_q;
    logic [BW-1:0]            bit_cnt_q;
    logic [FRAME_LEN-1:0]     mosi_sr_q, miso_sr_q;
    logic [FRAME_LEN-1:0]     mosi_sr_d, miso_sr_d;
    logic [FRAME_LEN-1:0]     miso_hold_q;
    logic [FRAME_LEN-1:0]     tx_data_q;
    logic                     tx_valid_q;
    logic                     word_sel_q;
    logic                     done_q;
    logic                     overflow_q;
    logic [CW-1:0]            count_q, count_d;
    logic [CW-1:0]            rd_ptr_q;
    logic [AW-1:0]            wr_ptr_q;

    logic [2*FRAME_LEN-1:0]   mem [DEPTH];
    logic [2*FRAME_LEN-1:0]   rd_data;

    logic sample, frame_end, store;

    assign sample    = (state_q == ST_CAPTURE) & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign frame_end = sample & (bit_cnt_q == BW'(FRAME_LEN - 1));
    assign store     = frame_end & (count_q < CW'(DEPTH));
    assign mosi_sr_d = {mosi_sr_q[FRAME_LEN-2:0], mosi_s};
    assign miso_sr_d = {miso_sr_q[FRAME_LEN-2:0], miso_s};
    // Includes a frame completed this cycle, so a coincident SS rise still sees it.
    assign count_d   = count_q + CW'(store);
    assign rd_data   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_12) begin
        if (store) begin
            mem[wr_ptr_q] <= {mosi_sr_d, miso_sr_d};
        end
    end

    always_ff @(posedge clk_12) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            arm_q       <= 1'b0;
            bit_cnt_q   <= '0;
            mosi_sr_q   <= '0;
            miso_sr_q   <= '0;
            miso_hold_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            word_sel_q  <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            arm_q  <= arm;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arm && !arm_q) begin
                        state_q    <= ST_ARMED;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        wr_ptr_q   <= '0;
                    end
                end
                ST_ARMED: begin
                    if (ss_fall) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample) begin
                        mosi_sr_q <= mosi_sr_d;
                        miso_sr_q <= miso_sr_d;
                        bit_cnt_q <= frame_end ? '0 : bit_cnt_q + BW'(1);
                    end
                    if (store) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                    end
                    if (frame_end && !store) begin
                        overflow_q <= 1'b1;
                    end
                    count_q <= count_d;
                    if (ss_rise) begin
                        bit_cnt_q <= '0;
                        if (count_d != '0) begin
                            state_q    <= ST_DUMP;
                            rd_ptr_q   <= '0;
                            word_sel_q <= 1'b0;
                            tx_valid_q <= 1'b0;
                        end else begin
                            state_q <= ST_ARMED;
                        end
                    end
                end
                ST_DUMP: begin
                    // word_sel_q high means the MOSI word is showing and its MISO twin is held.
                    if (!tx_valid_q) begin
                        tx_data_q   <= rd_data[2*FRAME_LEN-1:FRAME_LEN];
                        miso_hold_q <= rd_data[FRAME_LEN-1:0];
                        rd_ptr_q    <= rd_ptr_q + CW'(1);
                        word_sel_q  <= 1'b1;
                        tx_valid_q  <= 1'b1;
                    end else if (tx.tx_ready) begin
                        if (word_sel_q) begin
                            tx_data_q  <= miso_hold_q;
                            word_sel_q <= 1'b0;
                        end else if (rd_ptr_q == count_q) begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            count_q    <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            tx_data_q   <= rd_data[2*FRAME_LEN-1:FRAME_LEN];
                            miso_hold_q <= rd_data[FRAME_LEN-1:0];
                            rd_ptr_q    <= rd_ptr_q + CW'(1);
                            word_sel_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign overflow    = overflow_q;
    assign frame_count = count_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_capture_ctrl.sv
// Directed bench for spi_capture_ctrl: sniffed SPI frames in, readout words checked against a queue.
module tb_spi_capture_ctrl;
  import spi_pkg::*;

  localparam int FL = 8;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk_12 = 1'b0;
  logic          rstn;
  logic          sclk, MOSI, MISO, SS, arm;
  logic          busy, overflow, done;
  logic [CW-1:0] frame_count;
  state_t        dbg_state;

  spi_capture_ctrl_if #(.W(FL)) tx_if ();

  int vectors = 0;
  int miscompares = 0;
  logic [FL-1:0] exp_q[$];

  always #5 clk_12 = ~clk_12;

  spi_capture_ctrl #(.FRAME_LEN(FL), .DEPTH(DP)) dut (
    .clk_12(clk_12), .rstn(rstn), .sclk(sclk), .MOSI(MOSI), .MISO(MISO), .SS(SS),
    .arm(arm), .tx(tx_if), .busy(busy), .overflow(overflow),
    .frame_count(frame_count), .done(done), .dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_12);
  endtask

  task automatic spi_bits(input logic [FL-1:0] mo, input logic [FL-1:0] mi, input int n);
    for (int i = FL - 1; i >= FL - n; i--) begin
      MOSI = mo[i];
      MISO = mi[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    wait_clk(2);
    arm = 1'b0;
    wait_clk(2);
  endtask

  task automatic ss_set(input logic v);
    SS = v;
    wait_clk(6);
  endtask

  task automatic push_pair(input logic [FL-1:0] mo, input logic [FL-1:0] mi);
    exp_q.push_back(mo);
    exp_q.push_back(mi);
  endtask

  // Accepts words until the queue empties, then checks the completion pulse.
  task automatic drain(input bit toggle);
    int cyc = 0;
    bit ready_ph = 1'b1;
    bit hold = 1'b0;
    logic [FL-1:0] held = '0;
    logic [FL-1:0] exp_w;
    while (exp_q.size() > 0 && cyc < 200) begin
      tx_if.tx_ready = toggle ? ready_ph : 1'b1;
      ready_ph = ~ready_ph;
      if (hold) begin
        check("hold_valid", 32'(tx_if.tx_valid), 32'(1));
        check("hold_data", 32'(tx_if.tx_data), 32'(held));
        hold = 1'b0;
      end
      if (tx_if.tx_valid) begin
        if (tx_if.tx_ready) begin
          exp_w = exp_q.pop_front();
          check("word", 32'(tx_if.tx_data), 32'(exp_w));
        end else begin
          held = tx_if.tx_data;
          hold = 1'b1;
        end
      end
      wait_clk(1);
      cyc++;
    end
    check("drain_left", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    tx_if.tx_ready = 1'b0;
    check("done_pulse", 32'(done), 32'(1));
    check("done_count", 32'(frame_count), 32'(0));
    check("done_busy", 32'(busy), 32'(0));
    check("done_valid", 32'(tx_if.tx_valid), 32'(0));
    wait_clk(1);
    check("done_low", 32'(done), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(tx_if.tx_valid), 32'(0));
    check({tag, "_data"}, 32'(tx_if.tx_data), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_ovf"}, 32'(overflow), 32'(0));
    check({tag, "_count"}, 32'(frame_count), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    rstn = 1'b0;
    sclk = 1'b0;
    MOSI = 1'b0;
    MISO = 1'b0;
    SS   = 1'b1;
    arm  = 1'b0;
    tx_if.tx_ready = 1'b0;
    wait_clk(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    wait_clk(2);

    // Single frame A5/3C
    arm_pulse();
    check("t1_armed", 32'(dbg_state), 32'(ST_ARMED));
    check("t1_busy", 32'(busy), 32'(1));
    ss_set(1'b0);
    check("t1_capture", 32'(dbg_state), 32'(ST_CAPTURE));
    spi_bits(8'hA5, 8'h3C, 8);
    ss_set(1'b1);
    check("t1_dump", 32'(dbg_state), 32'(ST_DUMP));
    check("t1_count", 32'(frame_count), 32'(1));
    push_pair(8'hA5, 8'h3C);
    drain(1'b0);

    // Three frames, consumer stalls every other cycle
    arm_pulse();
    ss_set(1'b0);
    spi_bits(8'h01, 8'h10, 8);
    spi_bits(8'h02, 8'h20, 8);
    spi_bits(8'h03, 8'h30, 8);
    ss_set(1'b1);
    check("t2_count", 32'(frame_count), 32'(3));
    push_pair(8'h01, 8'h10);
    push_pair(8'h02, 8'h20);
    push_pair(8'h03, 8'h30);
    drain(1'b1);

    // Partial frame is discarded
    arm_pulse();
    ss_set(1'b0);
    spi_bits(8'hFF, 8'hFF, 5);
    ss_set(1'b1);
    check("t3_armed", 32'(dbg_state), 32'(ST_ARMED));
    check("t3_valid", 32'(tx_if.tx_valid), 32'(0));
    check("t3_count", 32'(frame_count), 32'(0));
    arm_pulse();
    check("t3_arm_ignored", 32'(dbg_state), 32'(ST_ARMED));

    // Overflow: six frames into a four-entry buffer
    ss_set(1'b0);
    spi_bits(8'h11, 8'hEE, 8);
    spi_bits(8'h22, 8'hDD, 8);
    spi_bits(8'h33, 8'hCC, 8);
    spi_bits(8'h44, 8'hBB, 8);
    spi_bits(8'h55, 8'hAA, 8);
    spi_bits(8'h66, 8'h99, 8);
    ss_set(1'b1);
    check("t4_ovf", 32'(overflow), 32'(1));
    check("t4_count", 32'(frame_count), 32'(4));
    check("t4_dump", 32'(dbg_state), 32'(ST_DUMP));
    push_pair(8'h11, 8'hEE);
    push_pair(8'h22, 8'hDD);
    push_pair(8'h33, 8'hCC);
    push_pair(8'h44, 8'hBB);
    drain(1'b0);
    check("t4_ovf_hold", 32'(overflow), 32'(1));

    // Last sclk rise coincides with the SS rise
    arm_pulse();
    check("t5_ovf_clr", 32'(overflow), 32'(0));
    ss_set(1'b0);
    spi_bits(8'hC3, 8'h5A, 7);
    MOSI = 1'b1;
    MISO = 1'b0;
    wait_clk(4);
    sclk = 1'b1;
    SS   = 1'b1;
    wait_clk(6);
    sclk = 1'b0;
    wait_clk(2);
    check("t5_dump", 32'(dbg_state), 32'(ST_DUMP));
    check("t5_count", 32'(frame_count), 32'(1));
    push_pair(8'hC3, 8'h5A);
    drain(1'b0);

    // Reset in the middle of a dump, then a clean session
    arm_pulse();
    ss_set(1'b0);
    spi_bits(8'h12, 8'h34, 8);
    spi_bits(8'h56, 8'h78, 8);
    ss_set(1'b1);
    check("t6_first", 32'(tx_if.tx_data), 32'(8'h12));
    tx_if.tx_ready = 1'b1;
    wait_clk(1);
    tx_if.tx_ready = 1'b0;
    check("t6_second", 32'(tx_if.tx_data), 32'(8'h34));
    rstn = 1'b0;
    wait_clk(1);
    check_reset_outputs("t6_rst");
    rstn = 1'b1;
    wait_clk(2);
    arm_pulse();
    ss_set(1'b0);
    spi_bits(8'h9E, 8'h61, 8);
    ss_set(1'b1);
    check("t6_count", 32'(frame_count), 32'(1));
    push_pair(8'h9E, 8'h61);
    drain(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
